// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART echo path.
//   UART_DATA_WIDTH : byte width used on both sides of the elastic buffer.
//   FIFO_DEPTH_LOG2 : default log2 depth of the echo-path FIFO (16 entries).
//   tx_state_e      : drain FSM encoding (IDLE=0, START=1, WAIT_BUSY=2,
//                     WAIT_DONE=3).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy count and sticky overflow flag.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   push, push_data : write request and data; dropped when full
//   pop             : read request; ignored when empty
//   pop_data        : entry at the read pointer (valid while !empty)
//   full, empty     : decoded from the registered count
//   count           : occupancy, 0 .. 2**DEPTH_LOG2
//   overflow        : sticky, set on any dropped push
//   drop            : one-cycle indication that this cycle's push was dropped
// ---------------------------------------------------------------------------
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  // full comes from the registered count, so a same-cycle pop cannot make
  // room for a push into a full FIFO.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign drop  = push & full;

  // count never exceeds DEPTH, so its MSB alone marks the full state.
  assign full     = count[DEPTH_LOG2];
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (drop)  overflow <= 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_tx_fifo
// Elastic buffer between UART receiver and transmitter in the echo path.
// Every completed rx byte is queued; the drain FSM hands bytes to the
// transmitter one at a time, re-issuing tx_start if tx_busy never rises
// within BUSY_WAIT_MAX clocks.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   rx_done    : one-cycle pulse, rx_data holds a received byte
//   rx_data    : received byte
//   tx_busy    : transmitter framing a byte
//   tx_start   : one-cycle start pulse to the transmitter
//   tx_data    : registered byte to transmit, held until the frame ends
//   full/empty : FIFO occupancy flags
//   count      : FIFO occupancy
//   overflow   : sticky, at least one byte was dropped
//   drop_cnt   : (UART_FIFO_DROP_CNT_EN only) saturating dropped-byte count
// Build option: define UART_FIFO_DROP_CNT_EN to add the drop_cnt port.
// ---------------------------------------------------------------------------
module uart_rx_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int DEPTH_LOG2    = FIFO_DEPTH_LOG2,
  parameter int BUSY_WAIT_MAX = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
`ifdef UART_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int WAIT_W = $clog2(BUSY_WAIT_MAX + 1);

  tx_state_e             state;
  tx_state_e             state_nxt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  fifo_drop;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_done),
    .push_data (rx_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .drop      (fifo_drop)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        // A busy response wins over a timeout landing in the same cycle.
        // The counter reaches BUSY_WAIT_MAX on the edge that leaves here.
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == WAIT_W'(BUSY_WAIT_MAX - 1)) begin
          state_nxt = START;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tx_data  <= '0;
    end else begin
      state <= state_nxt;
      // tx_data only loads on the pop, so a re-issued start repeats the byte.
      if (pop) tx_data <= pop_data;
      if (state == START) begin
        wait_cnt <= '0;
      end else if (state == WAIT_BUSY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign tx_start = (state == START);

`ifdef UART_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (fifo_drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = fifo_drop;
`endif

endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_tx_fifo
// Self-checking bench for uart_rx_tx_fifo. A queue holds the bytes expected
// at the transmitter; a small transmitter model answers tx_start with busy.
// ---------------------------------------------------------------------------
module tb_uart_rx_tx_fifo;

  localparam int DW       = 8;
  localparam int DL       = 4;
  localparam int DEPTH    = 1 << DL;
  localparam int WAIT_MAX = 1023;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          full;
  logic          empty;
  logic [DL:0]   count;
  logic          overflow;
`ifdef UART_FIFO_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] q[$];
  bit            rx_fin;

  uart_rx_tx_fifo #(
    .DATA_WIDTH    (DW),
    .DEPTH_LOG2    (DL),
    .BUSY_WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
`ifdef UART_FIFO_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: consume n start pulses, checking bytes in order.
  task automatic drain(input int n, input string tag);
    int            w;
    logic [DW-1:0] exp;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (tx_start !== 1'b1 && w < 200) begin
        tick();
        w++;
      end
      n_cmp++;
      if (tx_start !== 1'b1) begin
        n_bad++;
        $display("FAIL %s start_timeout byte %0d: tx_start=%b required 1", tag, i, tx_start);
        return;
      end
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL %s unexpected_start byte %0d: queue empty, tx_data=%h", tag, i, tx_data);
        return;
      end
      exp = q.pop_front();
      if (tx_data !== exp) begin
        n_bad++;
        $display("FAIL %s tx_data byte %0d: got %h required %h", tag, i, tx_data, exp);
      end
      tx_busy = 1'b1;
      tick();
      n_cmp++;
      if (tx_start !== 1'b0) begin
        n_bad++;
        $display("FAIL %s start_double byte %0d: tx_start=%b required 0", tag, i, tx_start);
      end
      repeat ($urandom_range(1, 6)) tick();
      n_cmp++;
      if (tx_data !== exp) begin
        n_bad++;
        $display("FAIL %s tx_data_hold byte %0d: got %h required %h", tag, i, tx_data, exp);
      end
      tx_busy = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if ({tx_start, tx_data, count, empty, full, overflow} !== {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL %s reset_values: start=%b data=%h count=%0d empty=%b full=%b ovf=%b required 0 00 0 1 0 0",
               tag, tx_start, tx_data, count, empty, full, overflow);
    end
`ifdef UART_FIFO_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL %s drop_cnt_reset: got %0d required 0", tag, drop_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int highs;
    rx_data = 8'h41;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    n_cmp++;
    if (tx_start !== 1'b0 || count !== 5'd1) begin
      n_bad++;
      $display("FAIL single early: tx_start=%b count=%0d required 0 1", tx_start, count);
    end
    tick();
    n_cmp++;
    if (tx_start !== 1'b1 || tx_data !== 8'h41) begin
      n_bad++;
      $display("FAIL single start: tx_start=%b tx_data=%h required 1 41", tx_start, tx_data);
    end
    tx_busy = 1'b1;
    highs = 0;
    repeat (100) begin
      tick();
      if (tx_start === 1'b1) highs++;
    end
    tx_busy = 1'b0;
    repeat (4) begin
      tick();
      if (tx_start === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 0) begin
      n_bad++;
      $display("FAIL single extra_start: got %0d pulses required 0", highs);
    end
    n_cmp++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_bad++;
      $display("FAIL single end_empty: empty=%b count=%0d required 1 0", empty, count);
    end
  endtask

  task automatic test_burst();
    tx_busy = 1'b1;
    for (int b = 8'h30; b <= 8'h34; b++) begin
      rx_data = DW'(b);
      rx_done = 1'b1;
      q.push_back(DW'(b));
      tick();
    end
    rx_done = 1'b0;
    n_cmp++;
    if (count !== 5'd5) begin
      n_bad++;
      $display("FAIL burst count: got %0d required 5", count);
    end
    tx_busy = 1'b0;
    drain(5, "burst");
    repeat (3) tick();
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL burst end: count=%0d empty=%b required 0 1", count, empty);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] b;
    tx_busy = 1'b1;
    repeat (3) begin
      b = DW'($urandom);
      rx_data = b;
      rx_done = 1'b1;
      q.push_back(b);
      tick();
    end
    n_cmp++;
    if (count !== 5'd3) begin
      n_bad++;
      $display("FAIL simul pre_count: got %0d required 3", count);
    end
    // Release busy and push in the same cycle: pop and push coincide.
    b = DW'($urandom);
    rx_data = b;
    rx_done = 1'b1;
    q.push_back(b);
    tx_busy = 1'b0;
    tick();
    rx_done = 1'b0;
    n_cmp++;
    if (count !== 5'd3 || tx_start !== 1'b1) begin
      n_bad++;
      $display("FAIL simul count: count=%0d tx_start=%b required 3 1", count, tx_start);
    end
    drain(4, "simul");
    repeat (3) tick();
    n_cmp++;
    if (empty !== 1'b1) begin
      n_bad++;
      $display("FAIL simul end_empty: empty=%b required 1", empty);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] b;
    int            k;
    b = DW'($urandom);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    n_cmp++;
    if (tx_start !== 1'b1 || tx_data !== b) begin
      n_bad++;
      $display("FAIL timeout first_start: tx_start=%b tx_data=%h required 1 %h", tx_start, tx_data, b);
    end
    k = 0;
    do begin
      tick();
      k++;
    end while (tx_start !== 1'b1 && k < WAIT_MAX + 10);
    n_cmp++;
    if (k != WAIT_MAX + 1) begin
      n_bad++;
      $display("FAIL timeout interval: got %0d clocks required %0d", k, WAIT_MAX + 1);
    end
    n_cmp++;
    if (tx_data !== b || count !== 5'd0) begin
      n_bad++;
      $display("FAIL timeout repeat: tx_data=%h count=%0d required %h 0", tx_data, count, b);
    end
    tx_busy = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (empty !== 1'b1 || tx_start !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout end: empty=%b tx_start=%b required 1 0", empty, tx_start);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] b;
    tx_busy = 1'b1;
    repeat (DEPTH + 1) begin
      b = DW'($urandom);
      rx_data = b;
      rx_done = 1'b1;
      if (q.size() < DEPTH) q.push_back(b);
      tick();
    end
    rx_done = 1'b0;
    n_cmp++;
    if (full !== 1'b1 || count !== 5'(DEPTH) || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow flags: full=%b count=%0d ovf=%b required 1 %0d 1", full, count, overflow, DEPTH);
    end
`ifdef UART_FIFO_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL overflow drop_cnt_one: got %0d required 1", drop_cnt);
    end
    rx_done = 1'b1;
    repeat (300) begin
      rx_data = DW'($urandom);
      tick();
    end
    rx_done = 1'b0;
    n_cmp++;
    if (drop_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL overflow drop_cnt_sat: got %0d required 255", drop_cnt);
    end
`endif
    tx_busy = 1'b0;
    drain(DEPTH, "overflow");
    repeat (3) tick();
    n_cmp++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow end: empty=%b ovf=%b required 1 1", empty, overflow);
    end
  endtask

  task automatic test_random();
    int guard;
    rx_fin = 1'b0;
    guard  = 0;
    fork
      begin
        logic [DW-1:0] b;
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 15) == 0) begin
            b = DW'($urandom);
            rx_data = b;
            rx_done = 1'b1;
            q.push_back(b);
          end else begin
            rx_done = 1'b0;
          end
          tick();
        end
        rx_done = 1'b0;
        rx_fin  = 1'b1;
      end
      begin
        logic [DW-1:0] exp;
        while (!(rx_fin && q.size() == 0) && guard < 3000) begin
          if (tx_start === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
              n_bad++;
              $display("FAIL random unexpected_start: tx_data=%h", tx_data);
            end else begin
              exp = q.pop_front();
              if (tx_data !== exp) begin
                n_bad++;
                $display("FAIL random tx_data: got %h required %h", tx_data, exp);
              end
            end
            tx_busy = 1'b1;
            repeat ($urandom_range(2, 5)) tick();
            tx_busy = 1'b0;
          end
          tick();
          guard++;
        end
      end
    join
    n_cmp++;
    if (guard >= 3000) begin
      n_bad++;
      $display("FAIL random drain_timeout: %0d bytes left, required 0", q.size());
    end
    repeat (4) tick();
    n_cmp++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_bad++;
      $display("FAIL random end: empty=%b count=%0d required 1 0", empty, count);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] b;
    int            highs;
    tx_busy = 1'b0;
    b = DW'($urandom);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    n_cmp++;
    if (tx_start !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid start: tx_start=%b required 1", tx_start);
    end
    tx_busy = 1'b1;
    repeat (4) begin
      rx_data = DW'($urandom);
      rx_done = 1'b1;
      tick();
    end
    rx_done = 1'b0;
    n_cmp++;
    if (count !== 5'd4) begin
      n_bad++;
      $display("FAIL rstmid pre_count: got %0d required 4", count);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_values("rstmid");
    q.delete();
    tx_busy = 1'b0;
    highs = 0;
    repeat (20) begin
      tick();
      if (tx_start === 1'b1) highs++;
    end
    n_cmp++;
    if (highs != 0 || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid quiet: pulses=%0d empty=%b required 0 1", highs, empty);
    end
    b = DW'($urandom);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    n_cmp++;
    if (tx_start !== 1'b1 || tx_data !== b) begin
      n_bad++;
      $display("FAIL rstmid restart: tx_start=%b tx_data=%h required 1 %h", tx_start, tx_data, b);
    end
    tx_busy = 1'b1;
    repeat (3) tick();
    tx_busy = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simultaneous();
    test_timeout();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_tx_fifo.md
Name: uart_rx_tx_fifo

Overview:
- Elastic buffer between the UART receiver and the UART transmitter in the echo path.
- Captures every byte the receiver completes (`rx_done` pulse with `rx_data`) into a synchronous FIFO.
- Drains the FIFO into the transmitter one byte at a time: pulses `tx_start`, then holds `tx_data` stable until the transmitter reports the frame finished.
- Removes the byte loss that occurs when bytes arrive back-to-back while the transmitter is still busy.

Parameters:
- DATA_WIDTH, 8, byte width on both sides.
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).
- BUSY_WAIT_MAX, 1023, clocks to wait for `tx_busy` to rise after `tx_start` before re-issuing `tx_start`.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset, synchronous, active-low.
- rx_done  input  1  one-cycle pulse: `rx_data` holds a complete received byte.
- rx_data  input  DATA_WIDTH  received byte, valid when `rx_done`=1.
- tx_busy  input  1  high while the transmitter is framing a byte (start through stop).
- tx_start  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  DATA_WIDTH  byte to transmit; registered, stable from `tx_start` until `tx_busy` falls.
- full  output  1  FIFO holds 2^DEPTH_LOG2 entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  DEPTH_LOG2+1  current occupancy.
- overflow  output  1  sticky: at least one byte was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (`rst`=0 at a clk edge):
  - `tx_start`=0, `tx_data`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0.
  - Read/write pointers = 0; FSM = IDLE.
  - Memory contents are not reset.
  - Reset mid-transfer abandons the in-flight byte and all queued bytes.
- Write side:
  - On an edge with `rx_done`=1 and `full`=0: `mem[wr_ptr]`<=`rx_data`; `wr_ptr`++ (wraps modulo depth).
  - `rx_done`=1 with `full`=1: byte discarded, pointers unchanged, `overflow`<=1.
  - `full` is evaluated on the registered count. A pop in the same cycle does not rescue a push to a full FIFO.
- Count and flags:
  - `count`+1 on accepted push only; −1 on pop only; unchanged on simultaneous push and pop.
  - `full`/`empty` are decoded from the registered `count`.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `empty`=0 and `tx_busy`=0 → pop. `tx_data`<=`mem[rd_ptr]`; `rd_ptr`++; go to START.
  - START: `tx_start`=1 for exactly this cycle; clear wait counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - `tx_busy`=1 → WAIT_DONE.
    - Else wait counter +1. When it reaches BUSY_WAIT_MAX → START (re-issue pulse, same `tx_data`, no re-pop).
  - WAIT_DONE: `tx_busy`=0 → IDLE.
- Latency:
  - `rx_done` into an empty FIFO with an idle transmitter: `tx_start` is high 2 clocks after the `rx_done` edge.
  - Back-to-back bytes: the next pop occurs the cycle after WAIT_DONE returns to IDLE.
- Invariants:
  - `tx_data` never changes outside the IDLE→START transition.
  - `tx_start` is never high in two consecutive cycles.
  - `rx_done` may pulse in any FSM state; the write side is independent of the FSM.

Optional Feature:
- Macro: UART_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output port `drop_cnt` (8 bits).
  - `drop_cnt` increments on each discarded byte and saturates at 255.
  - Reset value 0.
- Undefined:
  - Port and counter are absent.
  - `overflow` is the only loss indication.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding (2-bit localparams IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3).
  - UART_DATA_WIDTH=8.
  - Default FIFO depth constant.
- Sub-module `sync_fifo`:
  - Holds memory, pointers, `count`, `full`/`empty`, and overflow detection.
  - Parameterised by DATA_WIDTH and DEPTH_LOG2.
  - The top level contains only the drain FSM and the optional drop counter.

Test Plan:
- Reset then single byte: `rx_done` with `rx_data`=0x41, `tx_busy`=0 → `tx_start` pulses once 2 clocks later with `tx_data`=0x41. Hold `tx_busy`=1 for 100 clocks then 0 → FSM returns to IDLE, `empty`=1.
- Burst while busy: hold `tx_busy`=1 and push 0x30..0x34 → `count`=5. Release `tx_busy` and model the transmitter → bytes emitted in order 0x30..0x34, one `tx_start` each, `count` ends at 0.
- Overflow: `tx_busy`=1, push 17 bytes at depth 16 → `full`=1, `count`=16, `overflow`=1. The 17th byte is absent from the drained sequence. With UART_FIFO_DROP_CNT_EN, `drop_cnt`=1; 300 further drops → `drop_cnt`=255.
- Simultaneous push and pop: push coincides with the IDLE pop while `count`=3 → `count` stays 3, no data lost or duplicated.
- Busy timeout: `tx_busy` held 0 after `tx_start` → `tx_start` re-pulses after BUSY_WAIT_MAX+1 clocks with unchanged `tx_data` and unchanged `count`.
- Reset mid-operation: `rst`=0 for one edge while in WAIT_DONE with `count`=4 → all outputs at reset values next cycle; no `tx_start` until a new `rx_done`.
